dmem_arbiter: RTL and testbench
===============================

# dmem_arbiter

Two-requester arbiter sharing the single `data_memory` port between the processor's load/store path (requester 0) and a serial boot/debug loader (requester 1). It latches one winning request, drives the memory for exactly one cycle, waits out the read latency, and returns read data with a one-cycle acknowledge pulse. It sits between the processor datapath and `data_memory`, replacing the direct ALU-result and register-data wiring into the memory's address and write-data inputs.

## Interface
- `RD_LAT`, default 1: cycles from the memory read-enable cycle to valid `mem_rdata`; legal range 1–7.
- `clock` in 1: single clock; all state updates on the rising edge.
- `reset` in 1: asynchronous, active-low; 0 forces the reset state immediately.
- `req0`, `req1` in 1: request; held high with fields stable until the matching ack.
- `addr0`, `addr1` in 32: byte address.
- `wdata0`, `wdata1` in 32: store data.
- `we0`, `we1` in 1: 1 = write, 0 = read.
- `size0`, `size1` in 2: access size, passed unchanged to the memory `size_in` input.
- `ack0`, `ack1` out 1: one-cycle completion pulse.
- `rdata0`, `rdata1` out 32: read data, valid in the ack cycle and held until the next ack to the same requester.
- `mem_addr` out 32, `mem_wdata` out 32, `mem_size` out 2: latched transaction fields.
- `mem_re`, `mem_we` out 1: memory strobes.
- `mem_rdata` in 32: memory read data.
- `busy` out 1: high in any state other than IDLE.

## Operation
- FSM states:
  - IDLE: if any `reqN`, select a winner, latch addr/wdata/we/size and the winner id, go to ISSUE; otherwise stay.
  - ISSUE: assert `mem_we` (write) or `mem_re` (read) for exactly this cycle. Write goes to DONE. Read loads the latency counter with `RD_LAT-1` and goes to WAIT.
  - WAIT: decrement the counter. When the counter is 0 and `mem_rdata` is sampled, register it into the winner's `rdata` and go to DONE.
  - DONE: pulse the winner's `ack` and go to IDLE.
- Arbitration is round-robin on a 1-bit `last` pointer:
  - Only one request pending: that request wins.
  - Both pending: the requester not equal to `last` wins.
  - `last` updates at grant (IDLE→ISSUE).
  - After reset, `last`=1, so requester 0 wins the first tie.
- `mem_addr`, `mem_wdata` and `mem_size` always reflect the latched registers. `mem_re` and `mem_we` are 0 outside ISSUE and are never both 1.
- A write's `rdata` is unchanged.
- Arbitration happens only in IDLE. A request that arrives later waits for the current transaction and is never preempted.
- A requester dropping `req` before its ack is a protocol violation. The latched transaction still completes and acks.
- Address and size are not checked; alignment and serial-I/O mapping belong to `data_memory`.

## Timing
- Reset values: state IDLE; all outputs 0, including `rdata0`/`rdata1` and `busy`; `last`=1; counter 0.
- Write: `req` seen high in IDLE at edge n, ISSUE in cycle n+1 (memory write at its end), ack in cycle n+2. The requester sees 2 cycles from the grant edge to the ack.
- Read: ack in cycle n+2+RD_LAT; RD_LAT=1 gives ack in cycle n+3.
- Throughput: the earliest next grant is the IDLE cycle after DONE. Back-to-back writes occupy 3 cycles each and reads 3+RD_LAT cycles each.
- Simultaneous `req0` and `req1` in IDLE: exactly one is granted. The other is granted in the next IDLE, provided it is still held.
- `reset` low in any state, including during ISSUE: strobes and ack drop combinationally-fast through the async clear, and no ack is issued for the in-flight transaction. That transaction's memory effect is undefined if reset overlaps the ISSUE edge.
- `req` asserted in the same cycle reset deasserts is sampled at the first rising edge with `reset`=1.

## Structure
- The shared package `dmem_pkg` holds:
  - the state encoding (IDLE, ISSUE, WAIT, DONE);
  - the size constants (byte, half, word) matching the memory's size encoding;
  - a request-bundle typedef {addr, wdata, we, size}.
- One sub-module, `rr_arb2`, holds the combinational winner select plus the `last` register. The FSM, latency counter and field registers stay in `dmem_arbiter`.

## Test plan
- Reset held, then released with no requests → all outputs 0 and `busy`=0 for 10 cycles.
- `req0` writes 0xDEADBEEF to 0x1000_0000 (size word) → `mem_we` high for exactly 1 cycle with those values, `ack0` 2 cycles after the grant edge, `ack1` never asserted.
- `req1` reads 0x1000_0000 with RD_LAT=1 and the memory model returning 0xDEADBEEF → `mem_re` high for 1 cycle, `ack1` at grant+3, `rdata1`=0xDEADBEEF held afterward.
- `req0` and `req1` held continuously with reads → grants alternate 0,1,0,1 starting with 0; no requester waits more than one transaction.
- RD_LAT=3, read from requester 0 → ack at grant+5; `mem_re` is not reasserted during WAIT.
- `reset` pulsed low during WAIT of a read → no ack, state IDLE, `rdata0` cleared to 0; the next request after release is granted with `last`=1 tie-break.

Source files
------------

// File: rtl/dmem_pkg.sv
// dmem_pkg
// Shared definitions for the data-memory arbiter slice.
//   - FSM state encoding (IDLE, ISSUE, WAIT, DONE)
//   - access-size constants matching data_memory's size_in encoding
//   - req_t: one requester's transaction fields {addr, wdata, we, size}
package dmem_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        we;
    logic [1:0]  size;
  } req_t;

endpackage

// File: rtl/rr_arb2.sv
// rr_arb2
// Two-way round-robin winner select with its 1-bit "last granted" pointer.
// Ports:
//   clock, reset (async, active-low)
//   req0, req1 : pending requests
//   grant      : high in the cycle a winner is accepted; updates last
//   win        : winning requester id (valid when any_req is high)
//   any_req    : at least one request pending
module rr_arb2 (
  input  logic clock,
  input  logic reset,
  input  logic req0,
  input  logic req1,
  input  logic grant,
  output logic win,
  output logic any_req
);

  logic last_q;
  logic last_d;

  // On a tie the requester that did not win last time gets the grant.
  always_comb begin
    win     = 1'b0;
    any_req = req0 | req1;
    if (req0 && req1) begin
      win = ~last_q;
    end else if (req1) begin
      win = 1'b1;
    end
    last_d = grant ? win : last_q;
  end

  // last resets to 1 so requester 0 takes the first tie.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      last_q <= 1'b1;
    end else begin
      last_q <= last_d;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter
// Shares the single data_memory port between the load/store path
// (requester 0) and the boot/debug loader (requester 1). One request is
// latched per transaction, the memory is strobed for one cycle, read
// latency is waited out, and a one-cycle ack returns to the winner.
// Ports:
//   clock, reset (async, active-low)
//   reqN/addrN/wdataN/weN/sizeN : requester N transaction, held until ackN
//   ackN, rdataN                : completion pulse and held read data
//   mem_addr/mem_wdata/mem_size : latched transaction fields
//   mem_re/mem_we               : memory strobes, ISSUE cycle only
//   mem_rdata                   : memory read data, valid RD_LAT cycles after mem_re
//   busy                        : arbiter not in IDLE
module dmem_arbiter
  import dmem_pkg::*;
#(
  parameter int unsigned RD_LAT = 1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req0,
  input  logic [31:0] addr0,
  input  logic [31:0] wdata0,
  input  logic        we0,
  input  logic [1:0]  size0,
  input  logic        req1,
  input  logic [31:0] addr1,
  input  logic [31:0] wdata1,
  input  logic        we1,
  input  logic [1:0]  size1,
  output logic        ack0,
  output logic        ack1,
  output logic [31:0] rdata0,
  output logic [31:0] rdata1,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [1:0]  mem_size,
  output logic        mem_re,
  output logic        mem_we,
  input  logic [31:0] mem_rdata,
  output logic        busy
);

  localparam logic [2:0] RD_LAT_M1 = 3'(RD_LAT - 1);

  logic [1:0]  state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  req_t        txn_q, txn_d;
  logic        win_id_q, win_id_d;
  logic [31:0] rdata0_q, rdata0_d;
  logic [31:0] rdata1_q, rdata1_d;

  logic win;
  logic any_req;
  logic grant;

  assign grant = (state_q == ST_IDLE) && any_req;

  rr_arb2 u_arb (
    .clock   (clock),
    .reset   (reset),
    .req0    (req0),
    .req1    (req1),
    .grant   (grant),
    .win     (win),
    .any_req (any_req)
  );

  // Transaction FSM. The counter holds the remaining WAIT cycles; the
  // read data is captured in the WAIT cycle where it reaches zero.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    txn_d    = txn_q;
    win_id_d = win_id_q;
    rdata0_d = rdata0_q;
    rdata1_d = rdata1_q;
    case (state_q)
      ST_IDLE: begin
        if (any_req) begin
          win_id_d = win;
          txn_d    = win ? '{addr: addr1, wdata: wdata1, we: we1, size: size1}
                         : '{addr: addr0, wdata: wdata0, we: we0, size: size0};
          state_d  = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (txn_q.we) begin
          state_d = ST_DONE;
        end else begin
          cnt_d   = RD_LAT_M1;
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (cnt_q == 3'd0) begin
          if (win_id_q) begin
            rdata1_d = mem_rdata;
          end else begin
            rdata0_d = mem_rdata;
          end
          state_d = ST_DONE;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q  <= ST_IDLE;
      cnt_q    <= 3'd0;
      txn_q    <= '0;
      win_id_q <= 1'b0;
      rdata0_q <= 32'd0;
      rdata1_q <= 32'd0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      txn_q    <= txn_d;
      win_id_q <= win_id_d;
      rdata0_q <= rdata0_d;
      rdata1_q <= rdata1_d;
    end
  end

  // Strobes and acks decode straight from the state flops so the async
  // clear removes them without waiting for a clock edge.
  assign mem_re    = (state_q == ST_ISSUE) && !txn_q.we;
  assign mem_we    = (state_q == ST_ISSUE) && txn_q.we;
  assign ack0      = (state_q == ST_DONE) && !win_id_q;
  assign ack1      = (state_q == ST_DONE) && win_id_q;
  assign busy      = (state_q != ST_IDLE);
  assign mem_addr  = txn_q.addr;
  assign mem_wdata = txn_q.wdata;
  assign mem_size  = txn_q.size;
  assign rdata0    = rdata0_q;
  assign rdata1    = rdata1_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter
// Directed bench for dmem_arbiter. Instance "dut" uses RD_LAT=1 with both
// requesters; instance "dut_b" uses RD_LAT=3 with requester 0 only. Each
// instance has its own small memory model whose read data is only valid
// in the cycle the latency says it should be.
module tb_dmem_arbiter;
  import dmem_pkg::*;

  logic        clock;
  logic        reset;

  logic        req0, req1, we0, we1;
  logic [31:0] addr0, addr1, wdata0, wdata1;
  logic [1:0]  size0, size1;
  logic        ack0, ack1, mem_re, mem_we, busy;
  logic [31:0] rdata0, rdata1, mem_addr, mem_wdata, mem_rdata;
  logic [1:0]  mem_size;

  logic        b_req0, b_we0;
  logic [31:0] b_addr0, b_wdata0;
  logic [1:0]  b_size0;
  logic        b_ack0, b_ack1, b_mem_re, b_mem_we, b_busy;
  logic [31:0] b_rdata0, b_rdata1, b_mem_addr, b_mem_wdata, b_mem_rdata;
  logic [1:0]  b_mem_size;

  int total;
  int bad;
  int acks;
  int seq [3];
  int stamp [3];
  int re_cnt;
  int re_at;
  int ack_at;

  dmem_arbiter #(.RD_LAT(1)) dut (
    .clock(clock), .reset(reset),
    .req0(req0), .addr0(addr0), .wdata0(wdata0), .we0(we0), .size0(size0),
    .req1(req1), .addr1(addr1), .wdata1(wdata1), .we1(we1), .size1(size1),
    .ack0(ack0), .ack1(ack1), .rdata0(rdata0), .rdata1(rdata1),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_size(mem_size),
    .mem_re(mem_re), .mem_we(mem_we), .mem_rdata(mem_rdata), .busy(busy)
  );

  dmem_arbiter #(.RD_LAT(3)) dut_b (
    .clock(clock), .reset(reset),
    .req0(b_req0), .addr0(b_addr0), .wdata0(b_wdata0), .we0(b_we0), .size0(b_size0),
    .req1(1'b0), .addr1(32'd0), .wdata1(32'd0), .we1(1'b0), .size1(2'd0),
    .ack0(b_ack0), .ack1(b_ack1), .rdata0(b_rdata0), .rdata1(b_rdata1),
    .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata), .mem_size(b_mem_size),
    .mem_re(b_mem_re), .mem_we(b_mem_we), .mem_rdata(b_mem_rdata), .busy(b_busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Memory model for dut: one-cycle read latency.
  logic [31:0] mem_a [0:15];
  logic        rv_a;
  logic [31:0] rd_a;
  always @(posedge clock) begin
    if (mem_we) mem_a[mem_addr[5:2]] <= mem_wdata;
    rv_a <= mem_re;
    rd_a <= mem_a[mem_addr[5:2]];
  end
  assign mem_rdata = rv_a ? rd_a : 32'hBAD0_BAD0;

  // Memory model for dut_b: three-cycle read latency.
  logic [31:0] mem_b [0:15];
  logic [2:0]  rv_b;
  logic [31:0] rd_b [0:2];
  always @(posedge clock) begin
    if (b_mem_we) mem_b[b_mem_addr[5:2]] <= b_mem_wdata;
    rv_b    <= {rv_b[1:0], b_mem_re};
    rd_b[0] <= mem_b[b_mem_addr[5:2]];
    rd_b[1] <= rd_b[0];
    rd_b[2] <= rd_b[1];
  end
  assign b_mem_rdata = rv_b[2] ? rd_b[2] : 32'hBAD0_BAD0;

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s got=%h exp=%h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input bit which, input logic req, input logic [31:0] addr,
                               input logic [31:0] wdata, input logic we, input logic [1:0] size);
    if (which) begin
      req1 = req; addr1 = addr; wdata1 = wdata; we1 = we; size1 = size;
    end else begin
      req0 = req; addr0 = addr; wdata0 = wdata; we0 = we; size0 = size;
    end
  endtask

  task automatic applyStimulusB(input logic req, input logic [31:0] addr,
                                input logic [31:0] wdata, input logic we);
    b_req0 = req; b_addr0 = addr; b_wdata0 = wdata; b_we0 = we; b_size0 = SIZE_WORD;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    reset = 1'b0;
    applyStimulus(1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 2'd0);
    applyStimulus(1'b1, 1'b0, 32'd0, 32'd0, 1'b0, 2'd0);
    applyStimulusB(1'b0, 32'd0, 32'd0, 1'b0);

    // Reset held, then released with no requests.
    repeat (3) tick;
    checkOutput("rst_ctrl", 32'({busy, ack0, ack1, mem_re, mem_we}), 32'd0);
    checkOutput("rst_data", mem_addr | mem_wdata | rdata0 | rdata1, 32'd0);
    reset = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick;
      checkOutput("idle_ctrl", 32'({busy, ack0, ack1, mem_re, mem_we, mem_size}), 32'd0);
      checkOutput("idle_data", mem_addr | mem_wdata | rdata0 | rdata1, 32'd0);
    end

    // Requester 0 word write.
    applyStimulus(1'b0, 1'b1, 32'h1000_0000, 32'hDEAD_BEEF, 1'b1, SIZE_WORD);
    tick;
    checkOutput("wr_issue_we", 32'({mem_we, mem_re, busy, ack0, ack1}), 32'b10100);
    checkOutput("wr_addr", mem_addr, 32'h1000_0000);
    checkOutput("wr_wdata", mem_wdata, 32'hDEAD_BEEF);
    checkOutput("wr_size", 32'(mem_size), 32'(SIZE_WORD));
    tick;
    checkOutput("wr_done", 32'({mem_we, mem_re, ack0, ack1}), 32'b0010);
    applyStimulus(1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 2'd0);
    tick;
    checkOutput("wr_idle", 32'({busy, ack0, ack1, mem_we}), 32'd0);

    // Requester 1 read, RD_LAT=1: ack at grant+3.
    applyStimulus(1'b1, 1'b1, 32'h1000_0000, 32'd0, 1'b0, SIZE_WORD);
    tick;
    checkOutput("rd_issue", 32'({mem_re, mem_we, ack1}), 32'b100);
    tick;
    checkOutput("rd_wait", 32'({mem_re, mem_we, ack1, busy}), 32'b0001);
    tick;
    checkOutput("rd_ack", 32'({ack1, ack0}), 32'b10);
    checkOutput("rd_rdata1", rdata1, 32'hDEAD_BEEF);
    applyStimulus(1'b1, 1'b0, 32'd0, 32'd0, 1'b0, 2'd0);
    tick;
    checkOutput("rd_after", 32'({ack1, busy}), 32'd0);
    checkOutput("rd_hold", rdata1, 32'hDEAD_BEEF);
    checkOutput("rd_r0", rdata0, 32'd0);

    // Tied writes: last=1 after requester 1, so requester 0 goes first.
    applyStimulus(1'b0, 1'b1, 32'h1000_0004, 32'h1111_1111, 1'b1, SIZE_WORD);
    applyStimulus(1'b1, 1'b1, 32'h1000_0008, 32'h2222_2222, 1'b1, SIZE_HALF);
    tick;
    checkOutput("tie_first_addr", mem_addr, 32'h1000_0004);
    tick;
    checkOutput("tie_first_ack", 32'({ack0, ack1}), 32'b10);
    applyStimulus(1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 2'd0);
    tick;
    checkOutput("tie_gap", 32'({busy, ack0, ack1}), 32'd0);
    tick;
    checkOutput("tie_second_addr", mem_addr, 32'h1000_0008);
    checkOutput("tie_second_size", 32'(mem_size), 32'(SIZE_HALF));
    checkOutput("tie_second_we", 32'(mem_we), 32'd1);
    tick;
    checkOutput("tie_second_ack", 32'({ack0, ack1}), 32'b01);
    applyStimulus(1'b1, 1'b0, 32'd0, 32'd0, 1'b0, 2'd0);
    tick;

    // Both requesters hold reads: grants alternate 0,1,0 every 4 cycles.
    applyStimulus(1'b0, 1'b1, 32'h1000_0004, 32'd0, 1'b0, SIZE_WORD);
    applyStimulus(1'b1, 1'b1, 32'h1000_0008, 32'd0, 1'b0, SIZE_WORD);
    acks = 0;
    for (int c = 1; c <= 40 && acks < 3; c++) begin
      tick;
      checkOutput("alt_dual_ack", 32'(ack0 & ack1), 32'd0);
      if (ack0) begin
        checkOutput("alt_rdata0", rdata0, 32'h1111_1111);
        seq[acks] = 0; stamp[acks] = c; acks++;
      end else if (ack1) begin
        checkOutput("alt_rdata1", rdata1, 32'h2222_2222);
        seq[acks] = 1; stamp[acks] = c; acks++;
      end
      if (acks == 3) begin
        req0 = 1'b0;
        req1 = 1'b0;
      end
    end
    checkOutput("alt_count", 32'(acks), 32'd3);
    if (acks == 3) begin
      checkOutput("alt_seq", 32'({seq[0][0], seq[1][0], seq[2][0]}), 32'b010);
      checkOutput("alt_t0", 32'(stamp[0]), 32'd3);
      checkOutput("alt_t1", 32'(stamp[1]), 32'd7);
      checkOutput("alt_t2", 32'(stamp[2]), 32'd11);
    end
    tick;
    tick;
    checkOutput("alt_idle", 32'({busy, ack0, ack1}), 32'd0);

    // RD_LAT=3 instance: seed a word, then read it back.
    applyStimulusB(1'b1, 32'h0000_0020, 32'hCAFE_F00D, 1'b1);
    tick;
    checkOutput("b_wr_issue", 32'({b_mem_we, b_mem_re}), 32'b10);
    checkOutput("b_wr_size", 32'(b_mem_size), 32'(SIZE_WORD));
    tick;
    checkOutput("b_wr_ack", 32'({b_ack0, b_ack1}), 32'b10);
    applyStimulusB(1'b0, 32'd0, 32'd0, 1'b0);
    tick;
    applyStimulusB(1'b1, 32'h0000_0020, 32'd0, 1'b0);
    re_cnt = 0; re_at = 0; ack_at = 0;
    for (int c = 1; c <= 8; c++) begin
      tick;
      if (b_mem_re) begin
        re_cnt++;
        re_at = c;
      end
      if (b_ack0) begin
        ack_at = c;
        checkOutput("b_rd_rdata0", b_rdata0, 32'hCAFE_F00D);
        applyStimulusB(1'b0, 32'd0, 32'd0, 1'b0);
      end
    end
    checkOutput("b_re_count", 32'(re_cnt), 32'd1);
    checkOutput("b_re_at", 32'(re_at), 32'd1);
    checkOutput("b_ack_at", 32'(ack_at), 32'd5);
    checkOutput("b_rdata0_hold", b_rdata0, 32'hCAFE_F00D);

    // Reset pulsed during WAIT of a RD_LAT=3 read.
    applyStimulusB(1'b1, 32'h0000_0020, 32'd0, 1'b0);
    tick;
    tick;
    checkOutput("b_in_wait", 32'({b_busy, b_mem_re, b_ack0}), 32'b100);
    reset = 1'b0;
    #1;
    checkOutput("b_rst_ctrl", 32'({b_busy, b_ack0, b_mem_re, b_mem_we}), 32'd0);
    checkOutput("b_rst_rdata0", b_rdata0, 32'd0);
    checkOutput("a_rst_rdata", rdata0 | rdata1, 32'd0);
    applyStimulusB(1'b0, 32'd0, 32'd0, 1'b0);
    for (int i = 0; i < 2; i++) begin
      tick;
      checkOutput("b_rst_noack", 32'({b_ack0, b_ack1, b_busy}), 32'd0);
    end
    // Release reset with a tie already present: requester 0 must win.
    reset = 1'b1;
    applyStimulus(1'b0, 1'b1, 32'h1000_0004, 32'd0, 1'b0, SIZE_WORD);
    applyStimulus(1'b1, 1'b1, 32'h1000_0008, 32'd0, 1'b0, SIZE_WORD);
    tick;
    checkOutput("post_rst_win", mem_addr, 32'h1000_0004);
    checkOutput("post_rst_re", 32'(mem_re), 32'd1);
    tick;
    tick;
    checkOutput("post_rst_ack", 32'({ack0, ack1}), 32'b10);
    checkOutput("post_rst_rdata0", rdata0, 32'h1111_1111);
    applyStimulus(1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 2'd0);
    applyStimulus(1'b1, 1'b0, 32'd0, 32'd0, 1'b0, 2'd0);
    tick;
    checkOutput("b_quiet", 32'({b_ack0, b_ack1, b_busy}), 32'd0);
    checkOutput("b_rdata1", b_rdata1, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
